rv_sim_mem: RTL and testbench



---
 rtl/rv_mem_pkg.sv | 20 ++
 rtl/rv_tx_fifo.sv | 52 +++++
 rtl/rv_sim_mem.sv | 136 +++++++++++++
 tb/tb_rv_sim_mem.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// Shared constants for the rv_sim_mem responder: NOP encoding, store sizes,
// UART MMIO offsets and status-word bit positions.
package rv_mem_pkg;

  localparam logic [31:0] RV_NOP = 32'h0000_0033;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [11:0] UART_OFS_DATA = 12'h000;
  localparam logic [11:0] UART_OFS_STAT = 12'h004;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_MISALIGN  = 3;
  localparam int ST_COUNT_LSB = 16;

endpackage

// File: rtl/rv_tx_fifo.sv
// First-word-fall-through byte FIFO for the UART transmit queue.
// A pop while full frees the slot used by a simultaneous push.
module rv_tx_fifo #(
  parameter int DEPTH = 16,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [7:0]    head
);

  logic [7:0]    store [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head reads as zero when empty so tx_data is clean out of reset.
  assign head    = empty ? 8'h00 : store[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rv_sim_mem.sv
// Instruction/data memory responder for rv_core with registered reads,
// lane-enabled stores, a backdoor loader and a memory-mapped UART TX queue.
module rv_sim_mem #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [31:0] UART_BASE   = 32'h0050_0000,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   pc,
  input  logic          instr_rd_en,
  output logic [31:0]   instr,
  input  logic [31:0]   mem_addr,
  input  logic [31:0]   mem_write_data,
  input  logic [1:0]    mem_size,
  input  logic          mem_data_rd_en,
  input  logic          mem_data_wr_en,
  output logic [31:0]   mem_read_data,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  output logic          tx_valid,
  output logic [7:0]    tx_data,
  input  logic          tx_ready,
  output logic          tx_overflow,
  output logic          misalign_err
);

  import rv_mem_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] pc_idx;
  logic [AW-1:0] d_idx;
  logic          mmio;
  logic [11:0]   ofs;
  logic          push;
  logic          stat_wr;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [31:0]   status;
  logic [31:0]   mmio_rdata;
  logic [31:0]   wr_word;
  logic [3:0]    wr_lanes;
  logic          misaligned;
  logic          core_we;
  logic          overflow_set;
  logic          misalign_set;
  logic          unused_bits;

  assign pc_idx      = pc[AW+1:2];
  assign d_idx       = mem_addr[AW+1:2];
  assign mmio        = (mem_addr[31:12] == UART_BASE[31:12]);
  assign ofs         = mem_addr[11:0];
  assign unused_bits = ^{pc[31:AW+2], pc[1:0]};

  assign push    = mem_data_wr_en && mmio && (ofs == UART_OFS_DATA);
  assign stat_wr = mem_data_wr_en && mmio && (ofs == UART_OFS_STAT);

  rv_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (mem_write_data[7:0]),
    .pop       (tx_ready),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head      (tx_data)
  );

  assign tx_valid = !empty;

  always_comb begin
    status                       = '0;
    status[ST_EMPTY]             = empty;
    status[ST_FULL]              = full;
    status[ST_OVERFLOW]          = tx_overflow;
    status[ST_MISALIGN]          = misalign_err;
    status[ST_COUNT_LSB +: 8]    = 8'(count);
    mmio_rdata = (ofs[11:2] == UART_OFS_STAT[11:2]) ? status : 32'h0;
  end

  // Store data is replicated across lanes so the lane enables alone pick the target bytes.
  always_comb begin
    wr_word    = mem_write_data;
    wr_lanes   = 4'b1111;
    misaligned = 1'b0;
    case (mem_size)
      SZ_B: begin
        wr_word  = {4{mem_write_data[7:0]}};
        wr_lanes = 4'b0001 << mem_addr[1:0];
      end
      SZ_H: begin
        wr_word    = {2{mem_write_data[15:0]}};
        wr_lanes   = mem_addr[1] ? 4'b1100 : 4'b0011;
        misaligned = mem_addr[0];
      end
      default: begin
        misaligned = (mem_addr[1:0] != 2'b00);
      end
    endcase
  end

  assign misalign_set = mem_data_wr_en && !mmio && misaligned;
  assign core_we      = mem_data_wr_en && !mmio && !misaligned && !(ld_en && (ld_addr == d_idx));
  assign overflow_set = push && full && !tx_ready;

  always_ff @(posedge clk) begin
    if (core_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_lanes[b]) mem[d_idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  // Reads sample the array before this edge's writes land (read-before-write).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr         <= RV_NOP;
      mem_read_data <= 32'h0;
      tx_overflow   <= 1'b0;
      misalign_err  <= 1'b0;
    end else begin
      if (instr_rd_en) instr <= mem[pc_idx];
      if (mem_data_rd_en) mem_read_data <= mmio ? mmio_rdata : mem[d_idx];
      tx_overflow  <= overflow_set || (tx_overflow && !(stat_wr && mem_write_data[2]));
      misalign_err <= misalign_set || (misalign_err && !(stat_wr && mem_write_data[3]));
    end
  end

endmodule

// File: tb/tb_rv_sim_mem.sv
// Self-checking bench for rv_sim_mem: directed scenarios plus randomized traffic
// compared each cycle against a word-array / byte-queue reference model.
module tb_rv_sim_mem;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [31:0] UART = 32'h0050_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        instr_rd_en;
  logic [31:0] instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [1:0]  mem_size;
  logic        mem_data_rd_en;
  logic        mem_data_wr_en;
  logic [31:0] mem_read_data;
  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        tx_overflow;
  logic        misalign_err;

  int vec_count  = 0;
  int fail_count = 0;

  logic [31:0] m_mem [1024];
  logic [7:0]  m_q [$];
  logic        m_ovf;
  logic        m_mis;
  logic [31:0] m_instr;
  logic [31:0] m_rdata;

  rv_sim_mem dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc             (pc),
    .instr_rd_en    (instr_rd_en),
    .instr          (instr),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_size       (mem_size),
    .mem_data_rd_en (mem_data_rd_en),
    .mem_data_wr_en (mem_data_wr_en),
    .mem_read_data  (mem_read_data),
    .ld_en          (ld_en),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .tx_overflow    (tx_overflow),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] modelStatus();
    logic [31:0] s;
    s = 32'(m_q.size()) << 16;
    s[0] = (m_q.size() == 0);
    s[1] = (m_q.size() == 16);
    s[2] = m_ovf;
    s[3] = m_mis;
    return s;
  endfunction

  // Reference behaviour for one clock edge, using the inputs currently driven.
  task automatic modelStep();
    logic        is_mmio;
    logic [9:0]  idx;
    logic [31:0] w;
    logic        mis_set;
    logic        ovf_set;
    is_mmio = (mem_addr[31:12] == UART[31:12]);
    idx     = mem_addr[11:2];
    mis_set = 1'b0;
    ovf_set = 1'b0;
    if (instr_rd_en) m_instr = m_mem[pc[11:2]];
    if (mem_data_rd_en) begin
      if (is_mmio) m_rdata = (mem_addr[11:2] == 10'd1) ? modelStatus() : 32'h0;
      else         m_rdata = m_mem[idx];
    end
    if (tx_ready && m_q.size() > 0) void'(m_q.pop_front());
    if (mem_data_wr_en && is_mmio && mem_addr[11:0] == 12'h000) begin
      if (m_q.size() < 16) m_q.push_back(mem_write_data[7:0]);
      else ovf_set = 1'b1;
    end
    if (mem_data_wr_en && is_mmio && mem_addr[11:0] == 12'h004) begin
      if (mem_write_data[2]) m_ovf = 1'b0;
      if (mem_data_wr_en && mem_write_data[3]) m_mis = 1'b0;
    end
    if (mem_data_wr_en && !is_mmio) begin
      w = m_mem[idx];
      if (mem_size == SZ_B) begin
        w[8*mem_addr[1:0] +: 8] = mem_write_data[7:0];
      end else if (mem_size == SZ_H) begin
        if (mem_addr[0]) mis_set = 1'b1;
        else w[16*mem_addr[1] +: 16] = mem_write_data[15:0];
      end else begin
        if (mem_addr[1:0] != 2'b00) mis_set = 1'b1;
        else w = mem_write_data;
      end
      if (!mis_set && !(ld_en && ld_addr == idx)) m_mem[idx] = w;
    end
    if (ovf_set) m_ovf = 1'b1;
    if (mis_set) m_mis = 1'b1;
    if (ld_en) m_mem[ld_addr] = ld_data;
  endtask

  task automatic compareAll();
    checkOutput("instr", instr, m_instr);
    checkOutput("mem_read_data", mem_read_data, m_rdata);
    checkOutput("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
    checkOutput("tx_data", 32'(tx_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
    checkOutput("tx_overflow", 32'(tx_overflow), 32'(m_ovf));
    checkOutput("misalign_err", 32'(misalign_err), 32'(m_mis));
  endtask

  task automatic applyStimulus(input logic [31:0] a_pc, input logic a_fetch,
                               input logic [31:0] a_addr, input logic [31:0] a_wdata,
                               input logic [1:0] a_size, input logic a_rd, input logic a_wr,
                               input logic a_ld, input logic [9:0] a_ld_addr,
                               input logic [31:0] a_ld_data, input logic a_ready);
    pc             = a_pc;
    instr_rd_en    = a_fetch;
    mem_addr       = a_addr;
    mem_write_data = a_wdata;
    mem_size       = a_size;
    mem_data_rd_en = a_rd;
    mem_data_wr_en = a_wr;
    ld_en          = a_ld;
    ld_addr        = a_ld_addr;
    ld_data        = a_ld_data;
    tx_ready       = a_ready;
    @(posedge clk);
    #1;
    modelStep();
    compareAll();
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(32'h0, 1'b0, 32'h0, 32'h0, SZ_W, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0, rdy);
  endtask

  task automatic storeOp(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz, input logic rdy);
    applyStimulus(32'h0, 1'b0, a, d, sz, 1'b0, 1'b1, 1'b0, 10'h0, 32'h0, rdy);
  endtask

  task automatic loadOp(input logic [31:0] a, input logic rdy);
    applyStimulus(32'h0, 1'b0, a, 32'h0, SZ_W, 1'b1, 1'b0, 1'b0, 10'h0, 32'h0, rdy);
  endtask

  task automatic randomCycle();
    logic [31:0] a;
    logic [31:0] p;
    logic [9:0]  la;
    logic [1:0]  pick;
    a = $urandom;
    if ($urandom_range(0, 3) == 0) begin
      pick = 2'($urandom_range(0, 3));
      a = UART | {26'h0, pick, 4'h0} >> 2;
      a = UART + 32'(pick) * 4;
    end else if (a[31:12] == UART[31:12]) begin
      a[31] = 1'b1;
    end
    p  = $urandom;
    la = ($urandom_range(0, 3) == 0) ? a[11:2] : 10'($urandom);
    applyStimulus(p, 1'($urandom), a, $urandom, 2'($urandom),
                  1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0),
                  la, $urandom, 1'($urandom));
  endtask

  initial begin
    rst_n = 1'b0;
    pc = 0; instr_rd_en = 0; mem_addr = 0; mem_write_data = 0; mem_size = 0;
    mem_data_rd_en = 0; mem_data_wr_en = 0; ld_en = 0; ld_addr = 0; ld_data = 0; tx_ready = 0;
    m_ovf = 0; m_mis = 0; m_instr = 32'h0000_0033; m_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_instr", instr, 32'h0000_0033);
    checkOutput("reset_rdata", mem_read_data, 32'h0);
    checkOutput("reset_tx_valid", 32'(tx_valid), 32'h0);
    checkOutput("reset_tx_data", 32'(tx_data), 32'h0);
    checkOutput("reset_overflow", 32'(tx_overflow), 32'h0);
    checkOutput("reset_misalign", 32'(misalign_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 1024; i++)
      applyStimulus(32'h0, 1'b0, 32'h0, 32'h0, SZ_W, 1'b0, 1'b0, 1'b1, 10'(i), $urandom, 1'b0);

    $display("[TB] fetch after backdoor load");
    applyStimulus(32'h0, 1'b0, 32'h0, 32'h0, SZ_W, 1'b0, 1'b0, 1'b1, 10'd1, 32'h0140_0193, 1'b0);
    applyStimulus(32'h4, 1'b1, 32'h0, 32'h0, SZ_W, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0);
    checkOutput("fetch_pc4", instr, 32'h0140_0193);
    applyStimulus(32'h8, 1'b0, 32'h0, 32'h0, SZ_W, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0);
    checkOutput("fetch_hold", instr, 32'h0140_0193);

    $display("[TB] UART push and drain");
    storeOp(UART, 32'h48, SZ_B, 1'b0);
    checkOutput("push_valid", 32'(tx_valid), 32'h1);
    checkOutput("push_data", 32'(tx_data), 32'h48);
    loadOp(UART + 32'h4, 1'b0);
    checkOutput("status_one", mem_read_data, 32'h0001_0000);
    idle(1'b1);
    checkOutput("drained", 32'(tx_valid), 32'h0);

    $display("[TB] overflow");
    for (int i = 0; i < 17; i++) storeOp(UART, 32'(i + 1), SZ_B, 1'b0);
    checkOutput("ovf_set", 32'(tx_overflow), 32'h1);
    loadOp(UART + 32'h4, 1'b0);
    checkOutput("status_full", mem_read_data, 32'h0010_0006);
    storeOp(UART + 32'h4, 32'h4, SZ_W, 1'b0);
    checkOutput("ovf_clear", 32'(tx_overflow), 32'h0);
    storeOp(UART, 32'h77, SZ_B, 1'b1);
    checkOutput("push_pop_full", 32'(tx_overflow), 32'h0);
    loadOp(UART + 32'h4, 1'b0);
    checkOutput("status_still_full", mem_read_data, 32'h0010_0002);
    repeat (17) idle(1'b1);

    $display("[TB] byte/half lanes");
    storeOp(32'h100, 32'h1122_3344, SZ_W, 1'b0);
    storeOp(32'h102, 32'h0000_00AA, SZ_B, 1'b0);
    loadOp(32'h100, 1'b0);
    checkOutput("sb_lane2", mem_read_data, 32'h11AA_3344);
    storeOp(32'h100, 32'h0000_BEEF, SZ_H, 1'b0);
    loadOp(32'h100, 1'b0);
    checkOutput("sh_low", mem_read_data, 32'h11AA_BEEF);

    $display("[TB] misalignment");
    storeOp(32'h101, 32'hDEAD_BEEF, SZ_W, 1'b0);
    checkOutput("mis_flag", 32'(misalign_err), 32'h1);
    loadOp(32'h100, 1'b0);
    checkOutput("mis_unchanged", mem_read_data, 32'h11AA_BEEF);
    loadOp(UART + 32'h4, 1'b0);
    checkOutput("mis_status_bit3", 32'(mem_read_data[3]), 32'h1);
    storeOp(UART + 32'h4, 32'h8, SZ_W, 1'b0);
    checkOutput("mis_clear", 32'(misalign_err), 32'h0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 1500; i++) randomCycle();

    $display("[TB] reset mid-drain");
    repeat (20) idle(1'b1);
    storeOp(32'h100, 32'hCAFE_F00D, SZ_W, 1'b0);
    for (int i = 0; i < 3; i++) storeOp(UART, 32'(8'hA0 + i), SZ_B, 1'b0);
    checkOutput("queued_valid", 32'(tx_valid), 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_tx_valid", 32'(tx_valid), 32'h0);
    checkOutput("async_instr", instr, 32'h0000_0033);
    checkOutput("async_tx_data", 32'(tx_data), 32'h0);
    m_q.delete();
    m_ovf = 0; m_mis = 0; m_instr = 32'h0000_0033; m_rdata = 0;
    @(negedge clk);
    rst_n = 1'b1;
    loadOp(32'h100, 1'b0);
    checkOutput("mem_retained", mem_read_data, 32'hCAFE_F00D);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
    $finish;
  end

endmodule
